// File: rtl/adder_pipe_pkg.sv
// Shared operation encoding and the {flag, c} arithmetic reference used by the
// adder pipeline and its testbench.
package adder_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'd0,
        OP_SUB     = 2'd1,
        OP_ADD_SAT = 2'd2,
        OP_SUB_SAT = 2'd3
    } op_e;

    localparam int MAX_W = 32;
    typedef logic [MAX_W:0] wide_t;

    // Result packs flag into bit MAX_W and the width-bit result into the low bits.
    function automatic wide_t compute(input logic [MAX_W-1:0] a,
                                      input logic [MAX_W-1:0] b,
                                      input op_e              op,
                                      input int               width);
        wide_t mask_s;
        wide_t sum_s;
        wide_t diff_s;
        wide_t res_s;
        logic  carry_s;
        logic  borrow_s;
        logic  flag_s;
        mask_s   = ({{MAX_W{1'b0}}, 1'b1} << width) - {{MAX_W{1'b0}}, 1'b1};
        sum_s    = {1'b0, a} + {1'b0, b};
        diff_s   = ({1'b0, a} - {1'b0, b}) & mask_s;
        carry_s  = |(sum_s & ~mask_s);
        borrow_s = (a < b);
        case (op)
            OP_ADD: begin
                res_s  = sum_s & mask_s;
                flag_s = carry_s;
            end
            OP_SUB: begin
                res_s  = diff_s;
                flag_s = borrow_s;
            end
            OP_ADD_SAT: begin
                res_s  = carry_s ? mask_s : sum_s;
                flag_s = carry_s;
            end
            OP_SUB_SAT: begin
                res_s  = borrow_s ? {(MAX_W+1){1'b0}} : diff_s;
                flag_s = borrow_s;
            end
            default: begin
                res_s  = {(MAX_W+1){1'b0}};
                flag_s = 1'b0;
            end
        endcase
        return {flag_s, res_s[MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One elastic register slot: holds {valid, data} and accepts new content
// whenever it is empty or its current content leaves this cycle.
module adder_pipe_stage #(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    assign up_ready = !valid_r || dn_ready;
    assign dn_valid = valid_r;
    assign dn_data  = data_r;

    // Slot register; data only moves on a real transfer so a stalled result holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else if (up_ready) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= up_data;
            end
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Elastic add/subtract pipeline with optional saturation, valid/ready on both
// sides and a running count of delivered results.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             flag,
    output logic [CNT_W-1:0] txn_count
);

    localparam int DATA_W = WIDTH + 1;

    wide_t             result_s;
    logic [DATA_W-1:0] stage0_data_s;
    logic              unused_s;

    // All arithmetic happens ahead of the first slot; later slots only carry data.
    always_comb begin
        result_s      = compute(MAX_W'(a), MAX_W'(b), op_e'(op), WIDTH);
        stage0_data_s = {result_s[MAX_W], result_s[WIDTH-1:0]};
    end

    assign unused_s = ^result_s;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        logic              up_valid_s;
        logic              up_ready_s;
        logic              dn_valid_s;
        logic              dn_ready_s;
        logic [DATA_W-1:0] up_data_s;
        logic [DATA_W-1:0] dn_data_s;

        if (i == 0) begin : g_head
            assign up_valid_s = in_valid;
            assign up_data_s  = stage0_data_s;
        end else begin : g_body
            assign up_valid_s = g_stage[i-1].dn_valid_s;
            assign up_data_s  = g_stage[i-1].dn_data_s;
        end

        // Ready ripples back from the consumer so a full pipe still streams.
        if (i == LATENCY - 1) begin : g_tail
            assign dn_ready_s = out_ready;
        end else begin : g_mid
            assign dn_ready_s = g_stage[i+1].up_ready_s;
        end

        adder_pipe_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .up_valid (up_valid_s),
            .up_ready (up_ready_s),
            .up_data  (up_data_s),
            .dn_valid (dn_valid_s),
            .dn_ready (dn_ready_s),
            .dn_data  (dn_data_s)
        );
    end

    assign in_ready    = g_stage[0].up_ready_s;
    assign out_valid   = g_stage[LATENCY-1].dn_valid_s;
    assign {flag, c}   = g_stage[LATENCY-1].dn_data_s;

    // Delivered-result counter, wraps silently at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            txn_count <= {CNT_W{1'b0}};
        end else if (out_valid && out_ready) begin
            txn_count <= txn_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed and random checks for adder_pipe with a queue scoreboard on the
// output handshake and a second instance to exercise counter wrap.
module tb_adder_pipe;
    import adder_pipe_pkg::*;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_w;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_valid_w;
    logic        out_ready;
    logic [7:0]  c;
    logic [7:0]  c_w;
    logic        flag;
    logic        flag_w;
    logic [15:0] txn_count;
    logic [3:0]  txn_count_w;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  sb[$];
    logic        stall_seen = 1'b0;
    logic [8:0]  held;
    logic [8:0]  exp_r;
    wide_t       ref_r;

    logic [7:0]  dir_a   [4] = '{8'hFF, 8'hFF, 8'h03, 8'h03};
    logic [7:0]  dir_b   [4] = '{8'h02, 8'h02, 8'h05, 8'h05};
    logic [1:0]  dir_op  [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    logic [7:0]  dir_c   [4] = '{8'h01, 8'hFF, 8'hFE, 8'h00};

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(8), .LATENCY(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .flag(flag), .txn_count(txn_count)
    );

    adder_pipe #(.WIDTH(8), .LATENCY(2), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
        .c(c_w), .flag(flag_w), .txn_count(txn_count_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: compare on output handshake, hold-check on stall, record accepts.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                checks++;
                assert (out_valid === 1'b1 && {flag, c} === held) else begin
                    errors++;
                    $error("FAIL stall_hold: observed %0b/%0h expected 1/%0h", out_valid, {flag, c}, held);
                end
            end
            stall_seen = out_valid && !out_ready;
            held       = {flag, c};
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_empty: observed result %0h expected no output", {flag, c});
                end
                if (sb.size() != 0) begin
                    exp_r = sb.pop_front();
                    checks++;
                    assert ({flag, c} === exp_r) else begin
                        errors++;
                        $error("FAIL result: observed %0h expected %0h", {flag, c}, exp_r);
                    end
                end
            end
            if (in_valid && in_ready) begin
                ref_r = compute(MAX_W'(a), MAX_W'(b), op_e'(op), W);
                sb.push_back({ref_r[MAX_W], ref_r[W-1:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int guard;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; op = OP_ADD;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_c", 32'(c), 32'h0);
        chk("rst_flag", 32'(flag), 32'h0);
        chk("rst_txn", 32'(txn_count), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Single ADD: visible two cycles after accept.
        a = 8'h0F; b = 8'h01; op = OP_ADD; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_early", 32'(out_valid), 32'h0);
        step();
        chk("lat_valid", 32'(out_valid), 32'h1);
        chk("lat_c", 32'(c), 32'h10);
        chk("lat_flag", 32'(flag), 32'h0);
        step();
        chk("lat_txn", 32'(txn_count), 32'h1);

        // Carry, clamp, borrow cases streamed back to back.
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                chk("dir_valid", 32'(out_valid), 32'h1);
                chk("dir_c", 32'(c), 32'(dir_c[k-2]));
                chk("dir_flag", 32'(flag), 32'h1);
            end
            if (k < 4) begin
                a = dir_a[k]; b = dir_b[k]; op = dir_op[k]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        chk("dir_txn", 32'(txn_count), 32'h5);

        // Backpressure: only two slots fill, result holds.
        out_ready = 1'b0;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            a = 8'h10 + 8'(j); b = 8'h01; op = OP_ADD; in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
            step();
        end
        chk("bp_accepted", 32'(acc), 32'h2);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_c_first", 32'(c), 32'h11);
        in_valid = 1'b0;
        repeat (2) step();
        chk("bp_c_hold", 32'(c), 32'h11);
        for (int k = 0; k < 4; k++) begin
            if (k < 2) begin
                a = 8'h12 + 8'(k); b = 8'h01; op = OP_ADD; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            #1;
            if (k < 2) chk("bp_resume_ready", 32'(in_ready), 32'h1);
            chk("bp_stream_valid", 32'(out_valid), 32'h1);
            chk("bp_stream_c", 32'(c), 32'h11 + 32'(k));
            step();
        end
        chk("bp_empty", 32'(out_valid), 32'h0);
        chk("bp_txn", 32'(txn_count), 32'h9);

        // Random stream with random consumer stalls.
        acc = 0; guard = 0;
        while (acc < 100 && guard < 2000) begin
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) acc++;
            step();
            guard++;
        end
        chk("rnd_accepted", 32'(acc), 32'd100);
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 50) begin
            step();
            guard++;
        end
        chk("rnd_drained", 32'(sb.size()), 32'h0);
        chk("rnd_txn", 32'(txn_count), 32'd109);

        // Reset with two results in flight.
        a = 8'h01; b = 8'h01; op = OP_ADD; in_valid = 1'b1;
        step();
        a = 8'h02;
        step();
        chk("inflight_valid", 32'(out_valid), 32'h1);
        reset = 1'b1; in_valid = 1'b0;
        step();
        reset = 1'b0;
        chk("rst2_valid", 32'(out_valid), 32'h0);
        chk("rst2_txn", 32'(txn_count), 32'h0);
        chk("rst2_in_ready", 32'(in_ready), 32'h1);
        chk("rst2_txn_w", 32'(txn_count_w), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst2_no_stale", 32'(out_valid), 32'h0);
        end

        // Counter wrap on the 4-bit instance.
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            a = 8'(k); b = 8'h03; op = OP_ADD; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("wrap_txn_w", 32'(txn_count_w), 32'h1);
        chk("wrap_txn", 32'(txn_count), 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
